// File: rtl/iter_mult32.sv
// rtl/iter_mult32.sv - 32x32 -> 64 unsigned shift-add multiplier, one bit per cycle (IDLE/RUN/DONE).
// Define MULT_OVF_EN to add the ovf output (product[63:32] nonzero), registered with product.
module iter_mult32 (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
`ifdef MULT_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic [32:0] sum;
  logic [63:0] acc_next;

  // Add into the upper half; the carry becomes the new MSB as the accumulator shifts right.
  always_comb begin
    sum      = {1'b0, acc[63:32]} + (mplier[0] ? {1'b0, mcand} : 33'd0);
    acc_next = {sum, acc[31:1]};
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= S_IDLE;
      count   <= 5'd0;
      mcand   <= 32'd0;
      mplier  <= 32'd0;
      acc     <= 64'd0;
      product <= 64'd0;
`ifdef MULT_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= 64'd0;
            count  <= 5'd0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          count  <= count + 5'd1;
          if (count == 5'd31) begin
            state   <= S_DONE;
            product <= acc_next;
`ifdef MULT_OVF_EN
            ovf     <= |acc_next[63:32];
`endif
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_iter_mult32.sv
// tb/tb_iter_mult32.sv - self-checking bench for iter_mult32: table vectors, random ops, corner sequences.
module tb_iter_mult32;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;
`ifdef MULT_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] hold;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t tbl[7];
  vec_t ops[3];

  always #5 clk = ~clk;

  iter_mult32 dut (
    .clk(clk),
    .clr(clr),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .product(product)
`ifdef MULT_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return {32'd0, x} * {32'd0, y};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Starts at +1 after an edge with the DUT idle; returns +1 after the DONE->IDLE edge.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [63:0] exp,
                        input string tag);
    int n;
    bit bad;
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    n = 0;
    bad = 1'b0;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1 || product !== hold) bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd32);
    chk({tag, "_run_busy_hold"}, {63'd0, bad}, 64'd0);
    chk({tag, "_product"}, product, exp);
    chk({tag, "_busy_in_done"}, {63'd0, busy}, 64'd1);
`ifdef MULT_OVF_EN
    chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, (exp[63:32] != 32'd0)});
`endif
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
    hold = exp;
  endtask

  initial begin
    int nd;
    int mode;
    bit bad;
    logic [31:0] ra;
    logic [31:0] rb;

    tbl[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
    tbl[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    tbl[2] = '{32'h1234_5678,  32'd0,          64'd0};
    tbl[3] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};
    tbl[4] = '{32'd0,          32'hFFFF_FFFF,  64'd0};
    tbl[5] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};
    tbl[6] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};

    clr = 1'b1;
    start = 1'b0;
    a = 32'd0;
    b = 32'd0;
    hold = 64'd0;
    #12;
    chk("reset_outputs", {busy, done, product}, 66'd0);
    clr = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_idle", {62'd0, busy, done}, 64'd0);

    for (int i = 0; i < 7; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].p, $sformatf("tbl%0d", i));

    repeat (5) @(posedge clk);
    #1;
    chk("idle_product_hold", product, hold);

    for (int i = 0; i < 20; i++) begin
      mode = $urandom_range(0, 3);
      ra = $urandom;
      rb = $urandom;
      if (mode == 1) begin ra = ra & 32'hFF; rb = rb & 32'hFFFF; end
      if (mode == 2) begin ra = ~(ra & 32'hF); rb = ~(rb & 32'h3); end
      run_op(ra, rb, ref_mul(ra, rb), $sformatf("rnd%0d", i));
    end

    // Operands and start churn during RUN/DONE must not disturb the accepted operation.
    a = 32'd7;
    b = 32'd9;
    start = 1'b1;
    @(posedge clk); #1;
    nd = 0;
    bad = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      start = 1'b1;
      a = $urandom;
      b = $urandom;
      @(posedge clk); #1;
      if (done === 1'b1) begin
        nd++;
        if (i != 32) bad = 1'b1;
        chk("churn_product", product, 64'd63);
      end
    end
    start = 1'b0;
    chk("churn_done_count", 64'(nd), 64'd1);
    chk("churn_done_timing", {63'd0, bad}, 64'd0);
    chk("churn_idle", {63'd0, busy}, 64'd0);
    hold = 64'd63;

    // Back-to-back with start held: accepts at edges 0, 34, 68.
    ops[0] = '{32'hDEAD_BEEF, 32'h0000_1234, ref_mul(32'hDEAD_BEEF, 32'h0000_1234)};
    ops[1] = '{32'hFFFF_FFFF, 32'h8000_0001, ref_mul(32'hFFFF_FFFF, 32'h8000_0001)};
    ops[2] = '{32'd11,        32'd13,        64'd143};
    nd = 0;
    for (int cyc = 0; cyc < 102; cyc++) begin
      start = 1'b1;
      a = ops[cyc / 34].a;
      b = ops[cyc / 34].b;
      @(posedge clk); #1;
      chk($sformatf("b2b_done_c%0d", cyc), {63'd0, done}, {63'd0, (cyc % 34 == 32)});
      if (done === 1'b1) begin
        nd++;
        chk($sformatf("b2b_product_c%0d", cyc), product, ops[cyc / 34].p);
      end
    end
    start = 1'b0;
    chk("b2b_done_count", 64'(nd), 64'd3);
    @(posedge clk); #1;
    chk("b2b_idle", {62'd0, busy, done}, 64'd0);
    hold = ops[2].p;

    // Abort mid-RUN with clr asserted between edges.
    a = 32'hFFFF;
    b = 32'hFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_running", {63'd0, busy}, 64'd1);
    #3;
    clr = 1'b1;
    #1;
    chk("abort_async_outputs", {busy, done, product}, 66'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    hold = 64'd0;
    nd = 0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) nd++;
      if (product !== 64'd0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    chk("abort_quiet", {63'd0, bad}, 64'd0);
    run_op(32'd6, 32'd7, 64'd42, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
